rns_dot_accum: RTL and testbench

- Eight-lane residue-number-system (RNS) multiply-accumulate stage that sits directly upstream of the full normalization pipeline.
- Takes streams of operand pairs, 8 digits of 18 bits each, and multiplies them digit-wise modulo each lane's modulus.
- Sums the products over a dot-product run terminated by in_last.
- Emits the non-normalized (intermediate-product) digit vector that the normalizer consumes.

---
 rtl/rns_dot_accum.sv | 146 ++++++++++++++
 tb/tb_rns_dot_accum.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rns_dot_accum.sv
// rns_dot_accum: eight-lane RNS multiply-accumulate ahead of the normalizer.
// Beats are registered on accept (S1), multiplied digit-wise (S2), reduced
// mod M_i (S3), then summed into a per-lane accumulator. A run ends on
// in_last, and the accumulated digit vector is presented on out_dig.
// Optional: define RNS_DOT_BEAT_CNT_EN to add out_count, the number of beats
// in the emitted run (saturating).

module rns_dot_lane #(
  parameter int unsigned DW  = 18,
  parameter int unsigned MOD = 65536
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          acc_v,
  input  logic          acc_last,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] res
);
  localparam logic [2*DW-1:0] MOD_P = (2*DW)'(MOD);
  localparam logic [DW:0]     MOD_S = (DW+1)'(MOD);

  logic [DW-1:0]   a_q, b_q, r_q, acc_q;
  logic [2*DW-1:0] p_q, prod;
  logic [DW:0]     sum, sum_red;

  // An empty accumulator holds 0, so acc+r covers both first and later beats
  always_comb begin
    prod    = (2*DW)'(a_q) * (2*DW)'(b_q);
    sum     = {1'b0, acc_q} + {1'b0, r_q};
    sum_red = (sum >= MOD_S) ? sum - MOD_S : sum;
  end

  // Operand -> product -> residue -> accumulate; everything freezes when en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      r_q   <= '0;
      acc_q <= '0;
      res   <= '0;
    end else if (en) begin
      a_q <= a;
      b_q <= b;
      p_q <= prod;
      r_q <= DW'(p_q % MOD_P);
      if (acc_v) begin
        if (acc_last) begin
          res   <= sum_red[DW-1:0];
          acc_q <= '0;
        end else begin
          acc_q <= sum_red[DW-1:0];
        end
      end
    end
  end
endmodule

module rns_dot_accum #(
  parameter int unsigned M0 = 65536,
  parameter int unsigned M1 = 78125,
  parameter int unsigned M2 = 117649,
  parameter int unsigned M3 = 177147,
  parameter int unsigned M4 = 262027,
  parameter int unsigned M5 = 262049,
  parameter int unsigned M6 = 262051,
  parameter int unsigned M7 = 262069,
  parameter int unsigned DW = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [8*DW-1:0] a_dig,
  input  logic [8*DW-1:0] b_dig,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef RNS_DOT_BEAT_CNT_EN
  output logic [15:0]     out_count,
`endif
  output logic [8*DW-1:0] out_dig
);
  localparam int NUM_LANES = 8;
  localparam int STAGES    = 3;
  localparam int unsigned MODS [NUM_LANES] = '{M0, M1, M2, M3, M4, M5, M6, M7};

  logic [NUM_LANES-1:0][DW-1:0] a_l, b_l, o_l;
  logic [STAGES:1]              vld_pipe, lst_pipe;
  logic                         stall, in_fire;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~rst;
  assign in_fire  = in_valid & in_ready;
  assign a_l      = a_dig;
  assign b_l      = b_dig;
  assign out_dig  = o_l;

  // Beat valid/last travel alongside the lane data; out_valid rises as a run completes
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      lst_pipe  <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], in_fire};
      lst_pipe  <= {lst_pipe[STAGES-1:1], in_fire & in_last};
      out_valid <= vld_pipe[STAGES] & lst_pipe[STAGES];
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rns_dot_lane #(.DW(DW), .MOD(MODS[g])) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (~stall),
      .acc_v    (vld_pipe[STAGES]),
      .acc_last (lst_pipe[STAGES]),
      .a        (a_l[g]),
      .b        (b_l[g]),
      .res      (o_l[g])
    );
  end

`ifdef RNS_DOT_BEAT_CNT_EN
  logic [15:0] beat_cnt, beat_inc;
  assign beat_inc = (beat_cnt == 16'hFFFF) ? 16'hFFFF : beat_cnt + 16'd1;

  // Count beats reaching the accumulator; publish the total with the result
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      out_count <= '0;
    end else if (!stall && vld_pipe[STAGES]) begin
      if (lst_pipe[STAGES]) begin
        out_count <= beat_inc;
        beat_cnt  <= '0;
      end else begin
        beat_cnt  <= beat_inc;
      end
    end
  end
`endif
endmodule

// File: tb/tb_rns_dot_accum.sv
// Directed bench for rns_dot_accum: table of single-beat vectors plus
// hand-written multi-cycle sequences (wrap, bubbles, backpressure, reset).
module tb_rns_dot_accum;
  localparam int DW = 18;
  localparam int W  = 8 * DW;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last;
  logic [W-1:0] a_dig, b_dig, out_dig;
  logic         out_valid, out_ready;
  logic [15:0]  cnt_obs;

`ifdef RNS_DOT_BEAT_CNT_EN
  logic [15:0] out_count;
  assign cnt_obs = out_count;
`else
  assign cnt_obs = 16'd0;
`endif

  rns_dot_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .a_dig     (a_dig),
    .b_dig     (b_dig),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef RNS_DOT_BEAT_CNT_EN
    .out_count (out_count),
`endif
    .out_dig   (out_dig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dig;
    logic [15:0]  cnt;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  res_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Record every completed output handshake
  always @(negedge clk)
    if (!rst && out_valid && out_ready) q.push_back('{out_dig, cnt_obs});

  function automatic logic [W-1:0] pk(input int unsigned l0, l1, l2, l3, l4, l5, l6, l7);
    pk = {DW'(l7), DW'(l6), DW'(l5), DW'(l4), DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  function automatic logic [W-1:0] rep(input int unsigned v);
    rep = pk(v, v, v, v, v, v, v, v);
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer one beat and hold it until accepted (bounded)
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    bit ok = 0;
    a_dig = a; b_dig = b; in_last = last; in_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{pk('h2000, 'h118c3, 'hf613, 'h2a4c5, 'h3c514, 'h2c3d0, 'h366b6, 'h122ca),
                pk('h3400, 'h38c7, 'h27e0, 'h4b1d, 'h1b96e, 'hc7fb, 'h28377, 'h21d67),
                pk('h0, 'h3d09, 'h18b37, 'hd89f, 'h5bbb, 'h3fd49, 'h2b67b, 'h2ef29)};
    vecs[1] = '{pk(65538, 78127, 117651, 177149, 262029, 262051, 262053, 262071),
                pk(65539, 78128, 117652, 177150, 262030, 262052, 262054, 262072),
                rep(6)};
    vecs[2] = '{rep('h3ffff), rep(1),
                pk(65535, 27768, 26845, 84996, 116, 94, 92, 74)};
    vecs[3] = '{rep(0), rep('h3ffff), rep(0)};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    a_dig = '0; b_dig = '0;
    idle(3);
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_dig", out_dig, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;

    // Single-beat vectors: latency of three edges after accept, then data
    for (int v = 0; v < 4; v++) begin
      q.delete();
      a_dig = vecs[v].a; b_dig = vecs[v].b; in_last = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", v), W'(in_ready), W'(1));
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (k < 3) chk($sformatf("v%0d_lat%0d", v, k), W'(out_valid), W'(0));
        else begin
          chk($sformatf("v%0d_valid", v), W'(out_valid), W'(1));
          chk($sformatf("v%0d_dig", v), out_dig, vecs[v].exp);
        end
        @(posedge clk); #1;
      end
      idle(2);
      chk($sformatf("v%0d_pulses", v), W'(q.size()), W'(1));
    end

    // Wrap-around: (M-1) + 1 == 0 in every lane
    q.delete();
    send(pk(65535, 78124, 117648, 177146, 262026, 262048, 262050, 262068), rep(1), 1'b0);
    send(rep(1), rep(1), 1'b1);
    idle(8);
    chk("wrap_pulses", W'(q.size()), W'(1));
    if (q.size() > 0) chk("wrap_dig", q[0].dig, rep(0));

    // Four beats of 3*5 with a two-cycle bubble
    q.delete();
    send(rep(3), rep(5), 1'b0);
    send(rep(3), rep(5), 1'b0);
    idle(2);
    send(rep(3), rep(5), 1'b0);
    send(rep(3), rep(5), 1'b1);
    idle(8);
    chk("bubble_pulses", W'(q.size()), W'(1));
    if (q.size() > 0) chk("bubble_dig", q[0].dig, rep(60));

    // Backpressure: stream of single-beat runs k*1, out_ready low 5 cycles
    begin
      int k = 1;
      bit acc;
      q.delete();
      a_dig = rep(1); b_dig = rep(1); in_last = 1'b1; in_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
        out_ready = !(c >= 4 && c < 9);
        @(negedge clk);
        if (out_valid && !out_ready) begin
          chk($sformatf("bp_in_ready_c%0d", c), W'(in_ready), W'(0));
          chk($sformatf("bp_hold_c%0d", c), out_dig, rep(1));
        end
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (acc) begin
          k++;
          if (k > 8) begin in_valid = 1'b0; in_last = 1'b0; end
          else a_dig = rep(k);
        end
      end
      out_ready = 1'b1;
      chk("bp_count", W'(q.size()), W'(8));
      for (int i = 0; i < 8 && i < q.size(); i++)
        chk($sformatf("bp_order%0d", i), q[i].dig, rep(i + 1));
    end

    // Reset mid-run discards partial sums and in-flight beats
    q.delete();
    send(rep(3), rep(5), 1'b0);
    send(rep(3), rep(5), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", W'(in_ready), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    send(rep(7), rep(9), 1'b1);
    idle(8);
    chk("midrst_pulses", W'(q.size()), W'(1));
    if (q.size() > 0) chk("midrst_dig", q[0].dig, rep(63));

`ifdef RNS_DOT_BEAT_CNT_EN
    // Beat count: 5-beat run of 2*3, then 1-beat run of 1*1
    q.delete();
    for (int i = 0; i < 5; i++) send(rep(2), rep(3), i == 4);
    send(rep(1), rep(1), 1'b1);
    idle(8);
    chk("cnt_pulses", W'(q.size()), W'(2));
    if (q.size() > 1) begin
      chk("cnt_run5_dig", q[0].dig, rep(30));
      chk("cnt_run5", W'(q[0].cnt), W'(5));
      chk("cnt_run1_dig", q[1].dig, rep(1));
      chk("cnt_run1", W'(q[1].cnt), W'(1));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
